// File: rtl/rs_pkg.sv
// rs_pkg: shared constants and entry layout for the ALU reservation station.
package rs_pkg;

    localparam int RS_DEPTH   = 8;
    localparam int RS_ROB_W   = 4;
    localparam int RS_XLEN    = 32;
    localparam int RS_NUM_CDB = 2;

    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] B_TYPE = 7'b1100011;

    // Entry layout at the default widths; the station re-derives it per instance.
    typedef struct packed {
        logic [2:0]          op;
        logic [6:0]          itype;
        logic                other;
        logic [RS_ROB_W-1:0] rob_id;
        logic [RS_XLEN-1:0]  v1;
        logic [RS_XLEN-1:0]  v2;
        logic                dep1;
        logic                dep2;
        logic [RS_ROB_W-1:0] tag1;
        logic [RS_ROB_W-1:0] tag2;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// rs_age_matrix: pairwise older-than bits; grants the oldest requester.
module rs_age_matrix
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [DEPTH-1:0] i_alloc,
    input  logic [DEPTH-1:0] i_free,
    input  logic [DEPTH-1:0] i_req,
    output logic [DEPTH-1:0] o_gnt
);

    // r_older[i][j] set means entry i is older than entry j
    logic [DEPTH-1:0][DEPTH-1:0] r_older;
    logic [DEPTH-1:0][DEPTH-1:0] w_older_nxt;

    always_comb begin
        w_older_nxt = r_older;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (i_alloc[i])
                    w_older_nxt[i][j] = 1'b0;
                if (i_alloc[j] && i != j)
                    w_older_nxt[i][j] = 1'b1;
                if (i_free[i] || i_free[j])
                    w_older_nxt[i][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_older <= '0;
        else if (i_en)
            r_older <= i_clear ? '0 : w_older_nxt;
    end

    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_gnt[i] = i_req[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (i_req[j] && r_older[j][i])
                    o_gnt[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rs_station.sv
// rs_station: ALU reservation station with CDB wakeup, insert bypass
// and oldest-ready-first dispatch over a valid/ready handshake.
module rs_station
    import rs_pkg::*;
#(
    parameter int DEPTH   = RS_DEPTH,
    parameter int ROB_W   = RS_ROB_W,
    parameter int XLEN    = RS_XLEN,
    parameter int NUM_CDB = RS_NUM_CDB,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [6:0]               in_type,
    input  logic                     in_other,
    input  logic [ROB_W-1:0]         in_rob_id,
    input  logic [XLEN-1:0]          in_v1,
    input  logic [XLEN-1:0]          in_v2,
    input  logic                     in_dep1,
    input  logic                     in_dep2,
    input  logic [ROB_W-1:0]         in_tag1,
    input  logic [ROB_W-1:0]         in_tag2,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [2:0]               ex_op,
    output logic [6:0]               ex_type,
    output logic                     ex_other,
    output logic [ROB_W-1:0]         ex_rob_id,
    output logic [XLEN-1:0]          ex_v1,
    output logic [XLEN-1:0]          ex_v2,
    output logic [CNT_W-1:0]         count
);

    typedef struct packed {
        logic [2:0]       op;
        logic [6:0]       itype;
        logic             other;
        logic [ROB_W-1:0] rob_id;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic             dep1;
        logic             dep2;
        logic [ROB_W-1:0] tag1;
        logic [ROB_W-1:0] tag2;
    } ent_t;

    logic [DEPTH-1:0] r_busy;
    ent_t [DEPTH-1:0] r_ent;
    logic [CNT_W-1:0] r_count;

    ent_t [DEPTH-1:0] w_ent_nxt;
    ent_t             w_new;
    logic [DEPTH-1:0] w_free_oh;
    logic [DEPTH-1:0] w_alloc;
    logic [DEPTH-1:0] w_free;
    logic [DEPTH-1:0] w_req;
    logic [DEPTH-1:0] w_gnt;
    logic             w_ins;
    logic             w_disp;
    logic [XLEN:0]    w_byp1;
    logic [XLEN:0]    w_byp2;

    // {hit, value}; the lowest-numbered matching port wins
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [ROB_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*ROB_W-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]  vals
    );
        logic [XLEN:0] w_res;
        w_res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (vld[k] && tags[k*ROB_W +: ROB_W] == tag)
                w_res = {1'b1, vals[k*XLEN +: XLEN]};
        end
        return w_res;
    endfunction

    assign in_ready = rdy && !(&r_busy);
    assign w_ins    = in_valid && in_ready && !flush;

    always_comb begin
        w_free_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_oh    = '0;
                w_free_oh[i] = 1'b1;
            end
        end
    end

    assign w_alloc = w_ins ? w_free_oh : '0;

    always_comb begin
        w_byp1       = cdb_lookup(in_tag1, cdb_valid, cdb_tag, cdb_value);
        w_byp2       = cdb_lookup(in_tag2, cdb_valid, cdb_tag, cdb_value);
        w_new.op     = in_op;
        w_new.itype  = in_type;
        w_new.other  = in_other;
        w_new.rob_id = in_rob_id;
        w_new.tag1   = in_tag1;
        w_new.tag2   = in_tag2;
        w_new.dep1   = in_dep1 && !w_byp1[XLEN];
        w_new.dep2   = in_dep2 && !w_byp2[XLEN];
        w_new.v1     = (in_dep1 && w_byp1[XLEN]) ? w_byp1[XLEN-1:0] : in_v1;
        w_new.v2     = (in_dep2 && w_byp2[XLEN]) ? w_byp2[XLEN-1:0] : in_v2;
    end

    // Stale tags on already-ready operands are never compared
    always_comb begin
        logic [XLEN:0] w_wk1;
        logic [XLEN:0] w_wk2;
        for (int i = 0; i < DEPTH; i++) begin
            w_wk1 = cdb_lookup(r_ent[i].tag1, cdb_valid, cdb_tag, cdb_value);
            w_wk2 = cdb_lookup(r_ent[i].tag2, cdb_valid, cdb_tag, cdb_value);
            w_ent_nxt[i] = r_ent[i];
            if (r_busy[i] && r_ent[i].dep1 && w_wk1[XLEN]) begin
                w_ent_nxt[i].dep1 = 1'b0;
                w_ent_nxt[i].v1   = w_wk1[XLEN-1:0];
            end
            if (r_busy[i] && r_ent[i].dep2 && w_wk2[XLEN]) begin
                w_ent_nxt[i].dep2 = 1'b0;
                w_ent_nxt[i].v2   = w_wk2[XLEN-1:0];
            end
            if (w_alloc[i])
                w_ent_nxt[i] = w_new;
        end
    end

    always_comb begin
        w_req = '0;
        for (int i = 0; i < DEPTH; i++)
            w_req[i] = r_busy[i] && !r_ent[i].dep1 && !r_ent[i].dep2;
    end

    rs_age_matrix #(
        .DEPTH(DEPTH)
    ) u_age (
        .clk     (clk),
        .rst     (rst),
        .i_en    (rdy),
        .i_clear (flush),
        .i_alloc (w_alloc),
        .i_free  (w_free),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    assign ex_valid = rdy && !flush && (|w_req);
    assign w_disp   = ex_valid && ex_ready;
    assign w_free   = w_disp ? w_gnt : '0;

    always_comb begin
        ex_op     = '0;
        ex_type   = '0;
        ex_other  = 1'b0;
        ex_rob_id = '0;
        ex_v1     = '0;
        ex_v2     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_gnt[i]) begin
                ex_op     = r_ent[i].op;
                ex_type   = r_ent[i].itype;
                ex_other  = r_ent[i].other;
                ex_rob_id = r_ent[i].rob_id;
                ex_v1     = r_ent[i].v1;
                ex_v2     = r_ent[i].v2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= '0;
            r_ent   <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_busy  <= '0;
                r_count <= '0;
            end else begin
                r_busy  <= (r_busy & ~w_free) | w_alloc;
                r_ent   <= w_ent_nxt;
                r_count <= r_count + CNT_W'(w_ins) - CNT_W'(w_disp);
            end
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: directed and random stimulus checked against an
// in-order queue model of the reservation station.
module tb_rs_station;
    import rs_pkg::*;

    localparam int DEPTH   = 8;
    localparam int ROB_W   = 4;
    localparam int XLEN    = 32;
    localparam int NUM_CDB = 2;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic rst, rdy, flush;
    logic in_valid, in_ready;
    logic [2:0] in_op;
    logic [6:0] in_type;
    logic in_other;
    logic [ROB_W-1:0] in_rob_id, in_tag1, in_tag2;
    logic [XLEN-1:0] in_v1, in_v2;
    logic in_dep1, in_dep2;
    logic [NUM_CDB-1:0] cdb_valid;
    logic [NUM_CDB-1:0][ROB_W-1:0] cdb_tag;
    logic [NUM_CDB-1:0][XLEN-1:0] cdb_value;
    logic ex_valid, ex_ready;
    logic [2:0] ex_op;
    logic [6:0] ex_type;
    logic ex_other;
    logic [ROB_W-1:0] ex_rob_id;
    logic [XLEN-1:0] ex_v1, ex_v2;
    logic [CNT_W-1:0] count;

    int n_vec = 0;
    int n_err = 0;
    rs_entry_t q[$];

    rs_station #(
        .DEPTH(DEPTH), .ROB_W(ROB_W), .XLEN(XLEN),
        .NUM_CDB(NUM_CDB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_type(in_type), .in_other(in_other),
        .in_rob_id(in_rob_id), .in_v1(in_v1), .in_v2(in_v2),
        .in_dep1(in_dep1), .in_dep2(in_dep2),
        .in_tag1(in_tag1), .in_tag2(in_tag2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_type(ex_type), .ex_other(ex_other),
        .ex_rob_id(ex_rob_id), .ex_v1(ex_v1), .ex_v2(ex_v2),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    // Oldest entry whose operands are both available
    function automatic int m_sel();
        for (int i = 0; i < q.size(); i++)
            if (!q[i].dep1 && !q[i].dep2)
                return i;
        return -1;
    endfunction

    function automatic logic [32:0] m_cdb(input logic [ROB_W-1:0] t);
        for (int k = 0; k < NUM_CDB; k++)
            if (cdb_valid[k] && cdb_tag[k] == t)
                return {1'b1, cdb_value[k]};
        return '0;
    endfunction

    task automatic look();
        int s;
        logic ev;
        @(negedge clk);
        #1;
        s  = m_sel();
        ev = rdy && !flush && s >= 0;
        chk("ex_valid", ex_valid, ev);
        chk("in_ready", in_ready, rdy && q.size() < DEPTH);
        chk("count", count, q.size());
        if (ev) begin
            chk("ex_rob_id", ex_rob_id, q[s].rob_id);
            chk("ex_v1", ex_v1, q[s].v1);
            chk("ex_v2", ex_v2, q[s].v2);
            chk("ex_op", ex_op, q[s].op);
            chk("ex_type", ex_type, q[s].itype);
            chk("ex_other", ex_other, q[s].other);
        end
    endtask

    task automatic tick();
        int s;
        bit ins;
        logic [32:0] h;
        rs_entry_t e;
        @(posedge clk);
        if (rdy) begin
            if (flush) begin
                q.delete();
            end else begin
                ins = in_valid && q.size() < DEPTH;
                s = m_sel();
                if (s >= 0 && ex_ready)
                    q.delete(s);
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].dep1) begin
                        h = m_cdb(q[i].tag1);
                        if (h[32]) begin
                            q[i].dep1 = 1'b0;
                            q[i].v1 = h[31:0];
                        end
                    end
                    if (q[i].dep2) begin
                        h = m_cdb(q[i].tag2);
                        if (h[32]) begin
                            q[i].dep2 = 1'b0;
                            q[i].v2 = h[31:0];
                        end
                    end
                end
                if (ins) begin
                    e.op = in_op;
                    e.itype = in_type;
                    e.other = in_other;
                    e.rob_id = in_rob_id;
                    e.tag1 = in_tag1;
                    e.tag2 = in_tag2;
                    e.v1 = in_v1;
                    e.v2 = in_v2;
                    e.dep1 = in_dep1;
                    e.dep2 = in_dep2;
                    h = m_cdb(in_tag1);
                    if (in_dep1 && h[32]) begin
                        e.dep1 = 1'b0;
                        e.v1 = h[31:0];
                    end
                    h = m_cdb(in_tag2);
                    if (in_dep2 && h[32]) begin
                        e.dep2 = 1'b0;
                        e.v2 = h[31:0];
                    end
                    q.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_dep1   = 1'b0;
        in_dep2   = 1'b0;
        cdb_valid = '0;
        ex_ready  = 1'b0;
        flush     = 1'b0;
        rdy       = 1'b1;
    endtask

    task automatic put(input int rob, input logic [31:0] a,
                       input logic [31:0] b, input bit d1, input int t1,
                       input bit d2, input int t2);
        in_valid  = 1'b1;
        in_rob_id = ROB_W'(rob);
        in_v1     = a;
        in_v2     = b;
        in_dep1   = d1;
        in_dep2   = d2;
        in_tag1   = ROB_W'(t1);
        in_tag2   = ROB_W'(t2);
        in_op     = 3'($urandom);
        in_other  = 1'($urandom);
        case ($urandom_range(0, 2))
            0: in_type = I_TYPE;
            1: in_type = R_TYPE;
            default: in_type = B_TYPE;
        endcase
    endtask

    initial begin
        rs_entry_t e;
        rst = 1'b1;
        idle();
        in_op = '0; in_type = '0; in_other = 1'b0; in_rob_id = '0;
        in_v1 = '0; in_v2 = '0; in_tag1 = '0; in_tag2 = '0;
        cdb_tag = '0; cdb_value = '0;
        #3;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_ex_rob_id", ex_rob_id, 0);
        chk("rst_ex_v1", ex_v1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single ready instruction flows straight through
        idle(); put(3, 5, 7, 0, 0, 0, 0); look(); tick();
        idle(); ex_ready = 1'b1; look();
        chk("t1_rob", ex_rob_id, 3);
        chk("t1_v1", ex_v1, 5);
        chk("t1_v2", ex_v2, 7);
        chk("t1_cnt1", count, 1);
        tick();
        idle(); look(); chk("t1_cnt0", count, 0); tick();

        // younger ready entry overtakes a waiting one; CDB port 1 wakes it
        idle(); put(1, 0, 32'h22, 1, 6, 0, 0); look(); tick();
        idle(); put(2, 32'h33, 32'h44, 0, 0, 0, 0); look(); tick();
        idle(); ex_ready = 1'b1; look(); chk("t2_first", ex_rob_id, 2); tick();
        idle(); ex_ready = 1'b1;
        cdb_valid = 2'b10; cdb_tag[1] = 4'd6; cdb_value[1] = 32'hAB;
        look(); chk("t2_wait", ex_valid, 0); tick();
        idle(); ex_ready = 1'b1; look();
        chk("t2_rob", ex_rob_id, 1);
        chk("t2_v1", ex_v1, 32'hAB);
        tick();

        // insert bypass from CDB port 0
        idle(); put(5, 32'h55, 0, 0, 0, 1, 4);
        cdb_valid = 2'b01; cdb_tag[0] = 4'd4; cdb_value[0] = 32'h11;
        look(); tick();
        idle(); ex_ready = 1'b1; look();
        chk("t3_rob", ex_rob_id, 5);
        chk("t3_v2", ex_v2, 32'h11);
        tick();

        // fill with dependent entries, then free one slot
        for (int i = 0; i < DEPTH; i++) begin
            idle(); put(i, i, i, 1, 8 + i, 0, 0); look(); tick();
        end
        idle(); look();
        chk("t4_full_rdy", in_ready, 0);
        chk("t4_full_cnt", count, DEPTH);
        tick();
        idle(); put(12, 1, 2, 0, 0, 0, 0); look(); tick();
        idle(); cdb_valid = 2'b01; cdb_tag[0] = 4'd11; cdb_value[0] = 32'h99;
        look(); tick();
        idle(); ex_ready = 1'b1; look();
        chk("t4_rob", ex_rob_id, 3);
        chk("t4_still_full", in_ready, 0);
        tick();
        idle(); look();
        chk("t4_free_rdy", in_ready, 1);
        chk("t4_free_cnt", count, DEPTH - 1);
        tick();

        // flush beats a concurrent insert
        idle(); flush = 1'b1; put(13, 1, 1, 0, 0, 0, 0); look(); tick();
        idle(); look();
        chk("t6_cnt", count, 0);
        chk("t6_valid", ex_valid, 0);
        tick();

        // stalled ALU keeps the oldest selection
        idle(); put(10, 32'hA, 32'hA, 0, 0, 0, 0); look(); tick();
        idle(); put(11, 32'hB, 32'hB, 0, 0, 0, 0); look(); tick();
        for (int i = 0; i < 3; i++) begin
            idle(); look();
            chk("t5_hold_rob", ex_rob_id, 10);
            chk("t5_hold_cnt", count, 2);
            tick();
        end
        idle(); ex_ready = 1'b1; look(); chk("t5_a", ex_rob_id, 10); tick();
        idle(); ex_ready = 1'b1; look(); chk("t5_b", ex_rob_id, 11); tick();

        // random traffic with rdy stalls, flushes and CDB hits
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            ex_ready = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_valid[k] = 1'($urandom_range(0, 1));
                cdb_value[k] = $urandom;
                if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    e = q[$urandom_range(0, q.size() - 1)];
                    cdb_tag[k] = e.dep1 ? e.tag1 : e.tag2;
                end else begin
                    cdb_tag[k] = ROB_W'($urandom);
                end
            end
            if ($urandom_range(0, 9) < 6)
                put($urandom, $urandom, $urandom,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? int'(cdb_tag[0]) : int'($urandom),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? int'(cdb_tag[1]) : int'($urandom));
            look();
            tick();
        end

        // asynchronous reset in the middle of traffic
        idle(); put(7, 3, 4, 0, 0, 0, 0); look(); tick();
        idle();
        rst = 1'b1;
        #1;
        chk("arst_ex_valid", ex_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_ex_rob_id", ex_rob_id, 0);
        chk("arst_ex_v2", ex_v2, 0);
        q.delete();
        #2;
        rst = 1'b0;
        idle(); put(9, 32'h90, 32'h91, 0, 0, 0, 0); look(); tick();
        idle(); ex_ready = 1'b1; look(); chk("arst_after", ex_rob_id, 9); tick();
        idle(); look(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
